// File: rtl/tinyalu_pkg.sv
// Shared types for the TinyALU command path: op codes, the queued command
// record and the legality check used when a command is dispatched.
package tinyalu_pkg;

    typedef enum logic [2:0] {
        NO_OP = 3'b000,
        ADD   = 3'b001,
        AND   = 3'b010,
        XOR   = 3'b011,
        MUL   = 3'b100
    } op_e;

    // op is kept as raw bits so illegal codes survive the FIFO and can be echoed back
    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] op;
    } alu_cmd_t;

    function automatic logic is_legal_op(input logic [2:0] op);
        return op inside {NO_OP, ADD, AND, XOR, MUL};
    endfunction

endpackage

// File: rtl/tinyalu_cmd_fifo.sv
// Command FIFO between the stream front end and the ALU sequencer.
// Count, full and empty are registered so cmd_ready comes straight from a flop.
module tinyalu_cmd_fifo
    import tinyalu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     reset_n,
    input  logic     push_i,
    input  alu_cmd_t wdata_i,
    input  logic     pop_i,
    output alu_cmd_t rdata_o,
    output logic     full_o,
    output logic     empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

    alu_cmd_t        mem_q [DEPTH];
    logic [AW-1:0]   wrPtr_q;
    logic [AW-1:0]   rdPtr_q;
    logic [AW:0]     count_q;
    logic [AW:0]     count_d;
    logic            full_q;
    logic            empty_q;
    logic            doPush;
    logic            doPop;

    assign doPush  = push_i && !full_q;
    assign doPop   = pop_i && !empty_q;
    assign rdata_o = mem_q[rdPtr_q];
    assign full_o  = full_q;
    assign empty_o = empty_q;

    always_comb begin
        count_d = count_q;
        case ({doPush, doPop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            if (doPush) wrPtr_q <= wrPtr_q + 1'b1;
            if (doPop)  rdPtr_q <= rdPtr_q + 1'b1;
            count_q <= count_d;
            full_q  <= (count_d == DEPTH_C);
            empty_q <= (count_d == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (doPush) mem_q[wrPtr_q] <= wdata_i;
    end

endmodule

// File: rtl/tinyalu_driver.sv
// Start/done initiator for TinyALU: queues commands, runs one ALU transaction
// at a time with a timeout, and returns each result over a valid/ready stream.
module tinyalu_driver
    import tinyalu_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_a,
    input  logic [7:0]  cmd_b,
    input  logic [2:0]  cmd_op,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [2:0]  alu_op,
    output logic        alu_start,
    input  logic        alu_done,
    input  logic [15:0] alu_result,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_result,
    output logic [2:0]  rsp_op,
    output logic        rsp_err
);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TIMEOUT_C = TW'(TIMEOUT);

    state_e         state_q;
    logic [7:0]     aluA_q;
    logic [7:0]     aluB_q;
    logic [2:0]     aluOp_q;
    logic           aluStart_q;
    logic [TW-1:0]  tmo_q;
    logic           shortOp_q;
    logic           shortErr_q;
    logic           rspValid_q;
    logic [15:0]    rspResult_q;
    logic [2:0]     rspOp_q;
    logic           rspErr_q;

    alu_cmd_t       cmdIn;
    alu_cmd_t       head;
    logic           fifoFull;
    logic           fifoEmpty;
    logic           popHead;

    assign cmdIn   = '{a: cmd_a, b: cmd_b, op: cmd_op};
    assign popHead = (state_q == IDLE) && !fifoEmpty;

    tinyalu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (cmd_valid),
        .wdata_i (cmdIn),
        .pop_i   (popHead),
        .rdata_o (head),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty)
    );

    // no_op and illegal ops still spend one BUSY cycle (shortOp_q) so their
    // response timing matches; only no_op raises alu_start during it.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            aluA_q      <= '0;
            aluB_q      <= '0;
            aluOp_q     <= '0;
            aluStart_q  <= 1'b0;
            tmo_q       <= '0;
            shortOp_q   <= 1'b0;
            shortErr_q  <= 1'b0;
            rspValid_q  <= 1'b0;
            rspResult_q <= '0;
            rspOp_q     <= '0;
            rspErr_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!fifoEmpty) begin
                        state_q    <= BUSY;
                        rspOp_q    <= head.op;
                        tmo_q      <= '0;
                        shortOp_q  <= (head.op == NO_OP) || !is_legal_op(head.op);
                        shortErr_q <= !is_legal_op(head.op);
                        if (is_legal_op(head.op)) begin
                            aluA_q     <= head.a;
                            aluB_q     <= head.b;
                            aluOp_q    <= head.op;
                            aluStart_q <= 1'b1;
                        end
                    end
                end
                BUSY: begin
                    if (shortOp_q || alu_done || (tmo_q == TIMEOUT_C)) begin
                        aluStart_q <= 1'b0;
                        rspValid_q <= 1'b1;
                        state_q    <= RESP;
                        if (shortOp_q) begin
                            rspResult_q <= '0;
                            rspErr_q    <= shortErr_q;
                        end else if (alu_done) begin
                            rspResult_q <= alu_result;
                            rspErr_q    <= 1'b0;
                        end else begin
                            rspResult_q <= '0;
                            rspErr_q    <= 1'b1;
                        end
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rspValid_q <= 1'b0;
                        state_q    <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cmd_ready  = !fifoFull;
    assign alu_a      = aluA_q;
    assign alu_b      = aluB_q;
    assign alu_op     = aluOp_q;
    assign alu_start  = aluStart_q;
    assign rsp_valid  = rspValid_q;
    assign rsp_result = rspResult_q;
    assign rsp_op     = rspOp_q;
    assign rsp_err    = rspErr_q;

endmodule
